// File: rtl/paddle_pkg.sv
// Shared command/state encodings and default geometry for the paddle move scheduler.
// apply_move() is the single definition of the saturating paddle arithmetic.
package paddle_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_LEFT  = 2'd1,
    CMD_RIGHT = 2'd2,
    CMD_HOLD  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARB      = 2'd1,
    ST_MOVE     = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_L = 8'd108;
  localparam logic [7:0] ASCII_R = 8'd114;
  localparam logic [7:0] ASCII_D = 8'd100;

  localparam int unsigned DEF_STEP   = 50;
  localparam int unsigned DEF_MIN_X  = 50;
  localparam int unsigned DEF_MAX_X  = 590;
  localparam int unsigned DEF_INIT_X = 320;

  // 11-bit intermediate so that neither direction can wrap before clamping
  function automatic logic [9:0] apply_move(input logic [9:0]  x,
                                            input cmd_e        cmd,
                                            input logic [10:0] step,
                                            input logic [10:0] min_x,
                                            input logic [10:0] max_x);
    logic [10:0] x_ext;
    logic [10:0] res;
    x_ext = {1'b0, x};
    case (cmd)
      CMD_LEFT: begin
        if (x_ext < (min_x + step)) res = min_x;
        else                        res = x_ext - step;
      end
      CMD_RIGHT: begin
        if (x_ext > (max_x - step)) res = max_x;
        else                        res = x_ext + step;
      end
      CMD_HOLD: res = x_ext;
      default:  res = x_ext;
    endcase
    return res[9:0];
  endfunction

endpackage

// File: rtl/paddle_move_scheduler_if.sv
// Input/output bundle of the paddle move scheduler; master drives the requests,
// slave is the scheduler itself.
interface paddle_move_scheduler_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       btn_left;
  logic       btn_right;
  logic       frame_tick;
  logic [9:0] paddle_x;
  logic       move_valid;
  logic [1:0] grant;
  logic       fifo_full;
  logic [7:0] drop_count;

  modport master (
    output rx_valid, rx_data, btn_left, btn_right, frame_tick,
    input  paddle_x, move_valid, grant, fifo_full, drop_count
  );

  modport slave (
    input  rx_valid, rx_data, btn_left, btn_right, frame_tick,
    output paddle_x, move_valid, grant, fifo_full, drop_count
  );
endinterface

// File: rtl/paddle_cmd_fifo.sv
// Synchronous FIFO of 2-bit paddle commands with registered full/empty flags.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module paddle_cmd_fifo
  import paddle_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_e push_cmd,
  input  logic pop,
  output cmd_e head_cmd,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  cmd_e          mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          full_r;
  logic          empty_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  always_comb begin
    pop_ok_s  = pop && !empty_r;
    push_ok_s = push && (!full_r || pop_ok_s);
    if (push_ok_s && !pop_ok_s)      count_nxt_s = count_r + CW'(1);
    else if (!push_ok_s && pop_ok_s) count_nxt_s = count_r - CW'(1);
    else                             count_nxt_s = count_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= CMD_NONE;
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_cmd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
      empty_r <= (count_nxt_s == '0);
    end
  end

  assign head_cmd = mem_r[rd_ptr_r];
  assign full     = full_r;
  assign empty    = empty_r;

endmodule

// File: rtl/paddle_move_scheduler.sv
// Decodes UART commands, arbitrates them round-robin against the buttons once per
// frame and applies one saturating move per grant to the paddle X register.
module paddle_move_scheduler
  import paddle_pkg::*;
#(
  parameter int unsigned STEP        = DEF_STEP,
  parameter int unsigned MIN_X       = DEF_MIN_X,
  parameter int unsigned MAX_X       = DEF_MAX_X,
  parameter int unsigned INIT_X      = DEF_INIT_X,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_FRAMES = 1
) (
  input logic                     clk,
  input logic                     rst_n,
  paddle_move_scheduler_if.slave  bus
);

  localparam logic [10:0] STEP_C    = 11'(STEP);
  localparam logic [10:0] MIN_X_C   = 11'(MIN_X);
  localparam logic [10:0] MAX_X_C   = 11'(MAX_X);
  localparam logic [9:0]  INIT_X_C  = 10'(INIT_X);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_FRAMES - 1);

  state_e     state_r;
  state_e     state_nxt_s;
  logic       rr_btn_r;
  logic [7:0] hold_cnt_r;
  logic [9:0] paddle_x_r;
  logic       move_valid_r;
  logic [1:0] grant_r;
  logic [7:0] drop_count_r;

  logic       push_s;
  cmd_e       push_cmd_s;
  logic       pop_s;
  cmd_e       head_cmd_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;
  logic       drop_s;
  logic       btn_req_s;
  cmd_e       btn_cmd_s;
  logic       win_uart_s;
  logic       win_btn_s;
  cmd_e       move_cmd_s;

  // Byte decode: only l/r/d become commands, everything else vanishes uncounted
  always_comb begin
    push_s     = 1'b0;
    push_cmd_s = CMD_NONE;
    if (bus.rx_valid) begin
      case (bus.rx_data)
        ASCII_L: begin push_s = 1'b1; push_cmd_s = CMD_LEFT;  end
        ASCII_R: begin push_s = 1'b1; push_cmd_s = CMD_RIGHT; end
        ASCII_D: begin push_s = 1'b1; push_cmd_s = CMD_HOLD;  end
        default: begin push_s = 1'b0; push_cmd_s = CMD_NONE;  end
      endcase
    end else begin
      push_s     = 1'b0;
      push_cmd_s = CMD_NONE;
    end
  end

  paddle_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_s),
    .push_cmd (push_cmd_s),
    .pop      (pop_s),
    .head_cmd (head_cmd_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  assign drop_s    = push_s && fifo_full_s && !pop_s;
  assign btn_req_s = bus.btn_left ^ bus.btn_right;
  assign btn_cmd_s = bus.btn_left ? CMD_LEFT : CMD_RIGHT;

  // Next state and ARB decision; a request that vanished before ARB yields no move
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    win_uart_s  = 1'b0;
    win_btn_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.frame_tick && (!fifo_empty_s || btn_req_s)) state_nxt_s = ST_ARB;
        else                                                  state_nxt_s = ST_IDLE;
      end
      ST_ARB: begin
        if (!fifo_empty_s && (!btn_req_s || !rr_btn_r)) begin
          win_uart_s  = 1'b1;
          pop_s       = 1'b1;
          state_nxt_s = ST_MOVE;
        end else if (btn_req_s) begin
          win_btn_s   = 1'b1;
          state_nxt_s = ST_MOVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MOVE: state_nxt_s = ST_COOLDOWN;
      ST_COOLDOWN: begin
        if (bus.frame_tick && (hold_cnt_r == HOLD_LAST)) state_nxt_s = ST_IDLE;
        else                                             state_nxt_s = ST_COOLDOWN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase

    if (win_uart_s)     move_cmd_s = head_cmd_s;
    else if (win_btn_s) move_cmd_s = btn_cmd_s;
    else                move_cmd_s = CMD_NONE;
  end

  // State, cooldown frame counter and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= 8'd0;
      rr_btn_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_MOVE)                           hold_cnt_r <= 8'd0;
      else if (state_r == ST_COOLDOWN && bus.frame_tick) hold_cnt_r <= hold_cnt_r + 8'd1;
      if (win_uart_s)     rr_btn_r <= 1'b1;
      else if (win_btn_s) rr_btn_r <= 1'b0;
    end
  end

  // Outputs are registered at the ARB->MOVE edge so they are visible during MOVE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddle_x_r   <= INIT_X_C;
      move_valid_r <= 1'b0;
      grant_r      <= 2'b00;
      drop_count_r <= 8'd0;
    end else begin
      move_valid_r <= win_uart_s || win_btn_s;
      if (win_uart_s || win_btn_s) begin
        paddle_x_r <= apply_move(paddle_x_r, move_cmd_s, STEP_C, MIN_X_C, MAX_X_C);
        grant_r    <= win_uart_s ? 2'b01 : 2'b10;
      end
      if (drop_s && (drop_count_r != 8'hFF)) drop_count_r <= drop_count_r + 8'd1;
    end
  end

  assign bus.paddle_x   = paddle_x_r;
  assign bus.move_valid = move_valid_r;
  assign bus.grant      = grant_r;
  assign bus.fifo_full  = fifo_full_s;
  assign bus.drop_count = drop_count_r;

endmodule

// File: tb/tb_paddle_move_scheduler.sv
// Directed self-checking bench for paddle_move_scheduler (default parameters).
module tb_paddle_move_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  paddle_move_scheduler_if bus_if ();

  paddle_move_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  localparam logic [9:0] RIGHT_SEQ [7] = '{10'd370, 10'd420, 10'd470, 10'd520, 10'd570, 10'd590, 10'd590};
  localparam logic [9:0] LEFT_SEQ  [7] = '{10'd270, 10'd220, 10'd170, 10'd120, 10'd70, 10'd50, 10'd50};

  task automatic reset_dut();
    rst_n = 1'b0;
    bus_if.rx_valid = 1'b0; bus_if.rx_data = 8'd0;
    bus_if.btn_left = 1'b0; bus_if.btn_right = 1'b0; bus_if.frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_valid = 1'b1; bus_if.rx_data = b;
    @(negedge clk);
    bus_if.rx_valid = 1'b0;
  endtask

  // tick in cycle N; capture move_valid at N+1, N+2, N+3 and position/grant at N+2
  task automatic run_frame(output logic [2:0] mv, output logic [9:0] x, output logic [1:0] g);
    bus_if.frame_tick = 1'b1;
    @(negedge clk); bus_if.frame_tick = 1'b0; mv[2] = bus_if.move_valid;
    @(negedge clk); mv[1] = bus_if.move_valid; x = bus_if.paddle_x; g = bus_if.grant;
    @(negedge clk); mv[0] = bus_if.move_valid;
  endtask

  task automatic cool_frame();
    bus_if.frame_tick = 1'b1;
    @(negedge clk); bus_if.frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic quiet_frame(output logic any_mv);
    any_mv = 1'b0;
    bus_if.frame_tick = 1'b1;
    repeat (4) begin
      @(negedge clk); bus_if.frame_tick = 1'b0; any_mv = any_mv | bus_if.move_valid;
    end
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (bus_if.paddle_x !== 10'd320) begin errors++; $display("FAIL reset_x: got %0d want 320", bus_if.paddle_x); end
    checks++; if (bus_if.move_valid !== 1'b0) begin errors++; $display("FAIL reset_mv: got %b want 0", bus_if.move_valid); end
    checks++; if (bus_if.grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", bus_if.grant); end
    checks++; if (bus_if.fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus_if.fifo_full); end
    checks++; if (bus_if.drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", bus_if.drop_count); end
  endtask

  task automatic test_single_right();
    logic [2:0] mv; logic [9:0] x; logic [1:0] g;
    reset_dut();
    send_byte(8'd114);
    run_frame(mv, x, g);
    checks++; if (mv !== 3'b010) begin errors++; $display("FAIL single_pulse: got %b want 010", mv); end
    checks++; if (x !== 10'd370) begin errors++; $display("FAIL single_x: got %0d want 370", x); end
    checks++; if (g !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", g); end
    cool_frame();
  endtask

  task automatic test_saturation();
    logic [2:0] mv; logic [9:0] x; logic [1:0] g;
    reset_dut();
    for (int i = 0; i < 7; i++) begin
      send_byte(8'd114);
      run_frame(mv, x, g);
      cool_frame();
      checks++; if (x !== RIGHT_SEQ[i] || mv !== 3'b010) begin
        errors++; $display("FAIL sat_right[%0d]: got x=%0d mv=%b want x=%0d mv=010", i, x, mv, RIGHT_SEQ[i]);
      end
    end
    reset_dut();
    for (int i = 0; i < 7; i++) begin
      send_byte(8'd108);
      run_frame(mv, x, g);
      cool_frame();
      checks++; if (x !== LEFT_SEQ[i] || mv !== 3'b010) begin
        errors++; $display("FAIL sat_left[%0d]: got x=%0d mv=%b want x=%0d mv=010", i, x, mv, LEFT_SEQ[i]);
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [2:0] mv; logic [9:0] x; logic [1:0] g; logic any_mv;
    reset_dut();
    repeat (6) send_byte(8'd108);
    checks++; if (bus_if.fifo_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", bus_if.fifo_full); end
    checks++; if (bus_if.drop_count !== 8'd2) begin errors++; $display("FAIL full_drop: got %0d want 2", bus_if.drop_count); end
    for (int i = 0; i < 4; i++) begin
      run_frame(mv, x, g);
      cool_frame();
      checks++; if (x !== LEFT_SEQ[i]) begin errors++; $display("FAIL drain_x[%0d]: got %0d want %0d", i, x, LEFT_SEQ[i]); end
    end
    checks++; if (bus_if.fifo_full !== 1'b0) begin errors++; $display("FAIL drain_full: got %b want 0", bus_if.fifo_full); end
    quiet_frame(any_mv);
    checks++; if (any_mv !== 1'b0) begin errors++; $display("FAIL drain_empty: got move_valid=%b want 0", any_mv); end
  endtask

  task automatic test_push_pop_full();
    logic [2:0] mv; logic [9:0] x; logic [1:0] g;
    reset_dut();
    repeat (4) send_byte(8'd100);
    checks++; if (bus_if.fifo_full !== 1'b1) begin errors++; $display("FAIL pp_full: got %b want 1", bus_if.fifo_full); end
    bus_if.frame_tick = 1'b1;
    @(negedge clk); bus_if.frame_tick = 1'b0;
    bus_if.rx_valid = 1'b1; bus_if.rx_data = 8'd114;   // coincides with the ARB pop
    @(negedge clk); bus_if.rx_valid = 1'b0;
    checks++; if (bus_if.move_valid !== 1'b1 || bus_if.paddle_x !== 10'd320) begin
      errors++; $display("FAIL pp_hold: got mv=%b x=%0d want mv=1 x=320", bus_if.move_valid, bus_if.paddle_x);
    end
    checks++; if (bus_if.drop_count !== 8'd0 || bus_if.fifo_full !== 1'b1) begin
      errors++; $display("FAIL pp_accept: got drop=%0d full=%b want drop=0 full=1", bus_if.drop_count, bus_if.fifo_full);
    end
    @(negedge clk);
    cool_frame();
    repeat (4) begin run_frame(mv, x, g); cool_frame(); end
    checks++; if (x !== 10'd370) begin errors++; $display("FAIL pp_last: got %0d want 370", x); end
  endtask

  task automatic test_drop_saturation();
    reset_dut();
    repeat (264) send_byte(8'd114);
    checks++; if (bus_if.drop_count !== 8'd255) begin errors++; $display("FAIL drop_sat: got %0d want 255", bus_if.drop_count); end
  endtask

  task automatic test_round_robin();
    logic [2:0] mv; logic [9:0] x; logic [1:0] g;
    reset_dut();
    send_byte(8'd114);
    bus_if.btn_left = 1'b1;
    run_frame(mv, x, g); cool_frame();
    checks++; if (g !== 2'b01 || x !== 10'd370) begin errors++; $display("FAIL rr_first: got g=%b x=%0d want g=01 x=370", g, x); end
    run_frame(mv, x, g); cool_frame();
    checks++; if (g !== 2'b10 || x !== 10'd320) begin errors++; $display("FAIL rr_second: got g=%b x=%0d want g=10 x=320", g, x); end
    run_frame(mv, x, g); cool_frame();
    checks++; if (g !== 2'b10 || x !== 10'd270 || mv !== 3'b010) begin
      errors++; $display("FAIL rr_btn_only: got g=%b x=%0d mv=%b want g=10 x=270 mv=010", g, x, mv);
    end
    bus_if.btn_left = 1'b0;
  endtask

  task automatic test_ignore();
    logic [2:0] mv; logic [9:0] x; logic [1:0] g; logic any_mv;
    reset_dut();
    bus_if.btn_left = 1'b1; bus_if.btn_right = 1'b1;
    any_mv = 1'b0;
    repeat (3) begin logic m; quiet_frame(m); any_mv = any_mv | m; end
    checks++; if (any_mv !== 1'b0) begin errors++; $display("FAIL both_btn: got move_valid=%b want 0", any_mv); end
    send_byte(8'h78); send_byte(8'h00); send_byte(8'd100);
    run_frame(mv, x, g); cool_frame();
    checks++; if (mv !== 3'b010 || x !== 10'd320 || g !== 2'b01) begin
      errors++; $display("FAIL hold_move: got mv=%b x=%0d g=%b want mv=010 x=320 g=01", mv, x, g);
    end
    checks++; if (bus_if.drop_count !== 8'd0) begin errors++; $display("FAIL ignore_drop: got %0d want 0", bus_if.drop_count); end
    quiet_frame(any_mv);
    checks++; if (any_mv !== 1'b0) begin errors++; $display("FAIL ignore_queued: got move_valid=%b want 0", any_mv); end
    bus_if.btn_left = 1'b0; bus_if.btn_right = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [2:0] mv; logic [9:0] x; logic [1:0] g; logic any_mv;
    reset_dut();
    repeat (3) send_byte(8'd114);
    bus_if.frame_tick = 1'b1;
    @(negedge clk); bus_if.frame_tick = 1'b0;
    @(negedge clk);
    checks++; if (bus_if.move_valid !== 1'b1 || bus_if.paddle_x !== 10'd370) begin
      errors++; $display("FAIL mid_pre: got mv=%b x=%0d want mv=1 x=370", bus_if.move_valid, bus_if.paddle_x);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus_if.paddle_x !== 10'd320 || bus_if.move_valid !== 1'b0) begin
      errors++; $display("FAIL mid_async: got x=%0d mv=%b want x=320 mv=0", bus_if.paddle_x, bus_if.move_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    any_mv = 1'b0;
    repeat (2) begin logic m; quiet_frame(m); any_mv = any_mv | m; end
    checks++; if (any_mv !== 1'b0) begin errors++; $display("FAIL mid_flushed: got move_valid=%b want 0", any_mv); end
    send_byte(8'd108);
    run_frame(mv, x, g);
    checks++; if (mv !== 3'b010 || x !== 10'd270) begin errors++; $display("FAIL mid_resume: got mv=%b x=%0d want mv=010 x=270", mv, x); end
  endtask

  initial begin
    test_reset();
    test_single_right();
    test_saturation();
    test_fifo_full();
    test_push_pop_full();
    test_drop_saturation();
    test_round_robin();
    test_ignore();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
